// File: rtl/bitnet_stack.sv
// LIFO value stack for the CPU PUSH/POP instructions: the top word sits in a
// register, the words below it sit in a synchronous-read RAM.
module bitnet_stack #(
   parameter int X_SIZE = 1024,
   parameter int DEPTH  = 16,
   parameter int CW     = $clog2(DEPTH + 1)
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic [X_SIZE-1:0] push_data_in,
   input  logic              push_valid_in,
   output logic              push_ready_out,
   output logic [X_SIZE-1:0] top_out,
   output logic              top_valid_out,
   input  logic              pop_in,
   output logic [CW-1:0]     count_out
);

   localparam int AW = (DEPTH - 1 > 1) ? $clog2(DEPTH - 1) : 1;

   typedef enum logic {
      IDLE,
      REFILL
   } state_t;

   state_t            state, next_state;
   logic [CW-1:0]     count, next_count;
   logic [X_SIZE-1:0] top, next_top;
   logic [X_SIZE-1:0] rd_data;
   logic [X_SIZE-1:0] mem [DEPTH-1];
   logic [AW-1:0]     wr_addr, rd_addr;
   logic              push_fire, pop_fire;
   logic              mem_we, mem_re;

   assign push_ready_out = (state == IDLE) && (count < CW'(DEPTH));
   assign top_valid_out  = (state == IDLE) && (count != '0);
   assign top_out        = top;
   assign count_out      = count;

   assign push_fire = push_valid_in && push_ready_out;
   assign pop_fire  = pop_in && top_valid_out;

   // The old top goes to RAM[count-1]; the entry beneath it is RAM[count-2].
   assign wr_addr = AW'(count - CW'(1));
   assign rd_addr = AW'(count - CW'(2));

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state <= IDLE;
         count <= '0;
         top   <= '0;
      end else begin
         state <= next_state;
         count <= next_count;
         top   <= next_top;
      end
   end

   always_comb begin
      next_state = state;
      next_count = count;
      next_top   = top;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      case (state)
         IDLE: begin
            if (push_fire && pop_fire) begin
               // Replacing the top in place needs no RAM traffic.
               next_top = push_data_in;
            end else if (push_fire) begin
               mem_we     = (count != '0);
               next_top   = push_data_in;
               next_count = count + CW'(1);
            end else if (pop_fire) begin
               next_count = count - CW'(1);
               if (count != CW'(1)) begin
                  mem_re     = 1'b1;
                  next_state = REFILL;
               end
            end
         end
         REFILL: begin
            next_top   = rd_data;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk_in) begin
      if (mem_we) begin
         mem[wr_addr] <= top;
      end
      if (mem_re) begin
         rd_data <= mem[rd_addr];
      end
   end

   a_count_range: assert property (@(posedge clk_in) disable iff (!rst_n_in)
      count <= CW'(DEPTH));

   a_refill_one_cycle: assert property (@(posedge clk_in) disable iff (!rst_n_in)
      (state == REFILL) |=> (state == IDLE));

endmodule

// File: tb/tb_bitnet_stack.sv
// Scoreboard bench for bitnet_stack: popped words are predicted at issue time
// and checked by a monitor whenever a pop is presented to the stack.
module tb_bitnet_stack;

   localparam int XS = 32;
   localparam int DP = 16;
   localparam int CW = $clog2(DP + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [XS-1:0] push_data = '0;
   logic          push_valid = 1'b0;
   logic          push_ready;
   logic [XS-1:0] top;
   logic          top_valid;
   logic          pop = 1'b0;
   logic [CW-1:0] count;

   int checks = 0;
   int errors = 0;
   logic [XS-1:0] sb[$];

   bitnet_stack #(.X_SIZE(XS), .DEPTH(DP)) dut (
      .clk_in(clk),
      .rst_n_in(rst_n),
      .push_data_in(push_data),
      .push_valid_in(push_valid),
      .push_ready_out(push_ready),
      .top_out(top),
      .top_valid_out(top_valid),
      .pop_in(pop),
      .count_out(count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic pv, input logic [XS-1:0] d, input logic p);
      push_valid = pv;
      push_data  = d;
      pop        = p;
   endtask

   task automatic doReset();
      applyStimulus(1'b0, '0, 1'b0);
      rst_n = 1'b0;
      #1;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   // Monitor: every pop that the stack is about to accept must expose the predicted word.
   always @(negedge clk) begin
      if (rst_n && pop && top_valid) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_pop", 32'(top), 32'hFFFF_FFFF);
         end else begin
            checkOutput("popped_word", 32'(top), 32'(sb.pop_front()));
         end
      end
   end

   initial begin
      // Reset takes effect without a clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_valid", 32'(top_valid), 32'd0);
      checkOutput("rst_ready", 32'(push_ready), 32'd1);
      checkOutput("rst_count", 32'(count), 32'd0);
      checkOutput("rst_top", 32'(top), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Ordering
      applyStimulus(1'b1, 32'hA, 1'b0); tick();
      applyStimulus(1'b1, 32'hB, 1'b0); tick();
      applyStimulus(1'b1, 32'hC, 1'b0); tick();
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("order_count", 32'(count), 32'd3);
      checkOutput("order_top", 32'(top), 32'hC);
      sb.push_back(32'hC); sb.push_back(32'hB); sb.push_back(32'hA);
      applyStimulus(1'b0, '0, 1'b1);
      tick();
      checkOutput("bubble1_valid", 32'(top_valid), 32'd0);
      checkOutput("bubble1_count", 32'(count), 32'd2);
      tick();
      checkOutput("after_bubble1_top", 32'(top), 32'hB);
      tick();
      checkOutput("bubble2_valid", 32'(top_valid), 32'd0);
      tick();
      checkOutput("after_bubble2_top", 32'(top), 32'hA);
      tick();
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("drained_valid", 32'(top_valid), 32'd0);
      checkOutput("drained_count", 32'(count), 32'd0);

      // Full
      doReset();
      for (int i = 1; i <= DP; i++) begin
         applyStimulus(1'b1, XS'(i), 1'b0);
         tick();
      end
      checkOutput("full_count", 32'(count), 32'd16);
      checkOutput("full_ready", 32'(push_ready), 32'd0);
      applyStimulus(1'b1, 32'd17, 1'b0);
      tick(); tick();
      checkOutput("full_hold_count", 32'(count), 32'd16);
      checkOutput("full_hold_top", 32'(top), 32'd16);
      sb.push_back(32'd16);
      applyStimulus(1'b1, 32'd17, 1'b1);
      tick();
      applyStimulus(1'b1, 32'd17, 1'b0);
      checkOutput("full_refill_count", 32'(count), 32'd15);
      checkOutput("full_refill_ready", 32'(push_ready), 32'd0);
      tick();
      checkOutput("full_refilled_top", 32'(top), 32'd15);
      checkOutput("full_refilled_ready", 32'(push_ready), 32'd1);
      tick();
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("push17_top", 32'(top), 32'd17);
      checkOutput("push17_count", 32'(count), 32'd16);

      // Simultaneous push and pop
      doReset();
      applyStimulus(1'b1, 32'd1, 1'b0); tick();
      applyStimulus(1'b1, 32'd2, 1'b0); tick();
      sb.push_back(32'd2);
      applyStimulus(1'b1, 32'h55, 1'b1); tick();
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("simul_top", 32'(top), 32'h55);
      checkOutput("simul_count", 32'(count), 32'd2);
      checkOutput("simul_valid", 32'(top_valid), 32'd1);
      sb.push_back(32'h55);
      applyStimulus(1'b0, '0, 1'b1); tick();
      applyStimulus(1'b0, '0, 1'b0); tick();
      checkOutput("simul_pop_top", 32'(top), 32'd1);
      checkOutput("simul_pop_count", 32'(count), 32'd1);

      // Empty pop
      doReset();
      applyStimulus(1'b0, '0, 1'b1);
      tick(); tick();
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("empty_pop_count", 32'(count), 32'd0);
      checkOutput("empty_pop_valid", 32'(top_valid), 32'd0);
      applyStimulus(1'b1, 32'h7, 1'b0); tick();
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("empty_push_top", 32'(top), 32'h7);
      checkOutput("empty_push_count", 32'(count), 32'd1);

      // Reset during refill
      doReset();
      applyStimulus(1'b1, 32'd4, 1'b0); tick();
      applyStimulus(1'b1, 32'd5, 1'b0); tick();
      applyStimulus(1'b1, 32'd6, 1'b0); tick();
      sb.push_back(32'd6);
      applyStimulus(1'b0, '0, 1'b1); tick();
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("refill_valid", 32'(top_valid), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_count", 32'(count), 32'd0);
      checkOutput("midrst_valid", 32'(top_valid), 32'd0);
      checkOutput("midrst_ready", 32'(push_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checkOutput("midrst_idle_valid", 32'(top_valid), 32'd0);
      applyStimulus(1'b1, 32'h9, 1'b0); tick();
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("post_rst_top", 32'(top), 32'h9);
      checkOutput("post_rst_count", 32'(count), 32'd1);
      checkOutput("post_rst_valid", 32'(top_valid), 32'd1);

      tick();
      checkOutput("scoreboard_left", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
